// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, op type and legality check.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_OR  = 4'b0001;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_SUB = 4'b0110;

    // True for the four operations the ALU implements.
    function automatic logic is_valid_op(input alu_op_t op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB, wrapping arithmetic, zero result for unknown ops.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  alu_op_t           ALU_Operation,
    input  logic [DATA_W-1:0] Data1,
    input  logic [DATA_W-1:0] Data2,
    output logic [DATA_W-1:0] ALU_result,
    output logic              ZERO
);

    // Operation select; unsupported codes produce zero.
    always_comb begin
        ALU_result = '0;
        case (ALU_Operation)
            ALU_AND: ALU_result = Data1 & Data2;
            ALU_OR:  ALU_result = Data1 | Data2;
            ALU_ADD: ALU_result = Data1 + Data2;
            ALU_SUB: ALU_result = Data1 - Data2;
            default: ALU_result = '0;
        endcase
    end

    assign ZERO = (ALU_result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters with a
// single-entry registered response slot.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = ALU_OP_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][OP_W-1:0]   req_op,
    input  logic [1:0][DATA_W-1:0] req_data1,
    input  logic [1:0][DATA_W-1:0] req_data2,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [DATA_W-1:0]      rsp_result,
    output logic                   rsp_zero,
    output logic                   rsp_err
);

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_err_q, rsp_err_d;
    logic              last_grant_q, last_grant_d;

    logic              slot_free_c;
    logic              grant_c;
    logic              accept_c;
    logic [OP_W-1:0]   op_mux_c;
    logic [DATA_W-1:0] data1_mux_c;
    logic [DATA_W-1:0] data2_mux_c;
    logic [DATA_W-1:0] alu_result_c;
    logic              alu_zero_c;

    assign slot_free_c = !rsp_valid_q || rsp_ready;

    // Grant selection: lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_c = 1'b0;
        case (req_valid)
            2'b01:   grant_c = 1'b0;
            2'b10:   grant_c = 1'b1;
            2'b11:   grant_c = !last_grant_q;
            default: grant_c = 1'b0;
        endcase
    end

    assign accept_c  = (|req_valid) && slot_free_c && rst_n;
    assign req_ready = {grant_c, !grant_c} & {2{(|req_valid) && slot_free_c && rst_n}};

    assign op_mux_c    = req_op[grant_c];
    assign data1_mux_c = req_data1[grant_c];
    assign data2_mux_c = req_data2[grant_c];

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .ALU_Operation (ALU_OP_W'(op_mux_c)),
        .Data1         (data1_mux_c),
        .Data2         (data2_mux_c),
        .ALU_result    (alu_result_c),
        .ZERO          (alu_zero_c)
    );

    // Response slot next state: load on accept, clear valid on drain, hold otherwise.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        last_grant_d = last_grant_q;
        if (accept_c) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant_c;
            rsp_result_d = alu_result_c;
            rsp_zero_d   = alu_zero_c;
            rsp_err_d    = !is_valid_op(ALU_OP_W'(op_mux_c));
            last_grant_d = grant_c;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Slot and round-robin state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

endmodule
